// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared offsets, CTRL bit positions and FSM encoding for spi_master
package spi_master_pkg;

  // RIB slave s5 base; the interconnect decodes it, the block sees only the low bits
  localparam logic [31:0] SPI_S5_BASE = 32'h6000_0000;

  localparam logic [7:0] SPI_CTRL   = 8'h00;
  localparam logic [7:0] SPI_DATA   = 8'h04;
  localparam logic [7:0] SPI_STATUS = 8'h08;

  // CTRL layout: [7:0] div, [8] cpol, [9] cpha, [10] cs, [11] ie
  localparam int CTRL_CPOL = 8;
  localparam int CTRL_CPHA = 9;
  localparam int CTRL_CS   = 10;
  localparam int CTRL_IE   = 11;
  localparam int CTRL_W    = 12;

  // STATUS layout
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_master_clkgen.sv
// rtl/spi_master_clkgen.sv - SCK half-period divider and edge counter
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   i_run     : high while the master is shifting; low clears both counters
//   i_div     : half period is i_div+1 clk cycles
//   o_lead    : single-cycle strobe on even (leading) SCK edges
//   o_trail   : single-cycle strobe on odd (trailing) SCK edges
//   o_last    : single-cycle strobe on edge 15, the final trailing edge
module spi_clkgen (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic [7:0] i_div,
  output logic       o_lead,
  output logic       o_trail,
  output logic       o_last
);

  logic [7:0] r_half_cnt;
  logic [3:0] r_edge_cnt;
  logic       w_edge;

  // The half counter never exceeds i_div, so div = 255 fits in 8 bits
  assign w_edge  = i_run && (r_half_cnt == i_div);
  assign o_lead  = w_edge && !r_edge_cnt[0];
  assign o_trail = w_edge &&  r_edge_cnt[0];
  assign o_last  = w_edge && (r_edge_cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (rst || !i_run) begin
      r_half_cnt <= 8'd0;
      r_edge_cnt <= 4'd0;
    end else if (w_edge) begin
      r_half_cnt <= 8'd0;
      r_edge_cnt <= r_edge_cnt + 4'd1;
    end else begin
      r_half_cnt <= r_half_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - memory-mapped SPI master (RIB slave s5), 8-bit MSB-first frames
// Ports:
//   clk, rst                 : system clock, synchronous active-high reset
//   wr_en_i/wr_addr_i/wr_data_i : single-cycle register write
//   rd_addr_i/rd_data_o      : combinational register read
//   spi_sck/spi_mosi/spi_cs_n/spi_miso : SPI pins
//   spi_int_flag_o           : level interrupt, done & ie
module spi_master
  import spi_master_pkg::*;
#(
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] DIV_RST = 8'd24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        spi_int_flag_o
);

  spi_state_t        r_state;
  logic [CTRL_W-1:0] r_ctrl;
  logic [7:0]        r_div;
  logic              r_cpha;
  logic [7:0]        r_tx;
  logic [7:0]        r_rx;
  logic              r_busy;
  logic              r_done;
  logic              r_sck;
  logic              r_mosi;
  logic              r_cs_n;

  logic [ADDR_W-1:0] w_wr_off;
  logic [ADDR_W-1:0] w_rd_off;
  logic              w_wr_ctrl;
  logic              w_wr_data;
  logic              w_wr_status;
  logic              w_lead;
  logic              w_trail;
  logic              w_last;
  logic              w_unused_bits;

  assign w_wr_off    = wr_addr_i[ADDR_W-1:0];
  assign w_rd_off    = rd_addr_i[ADDR_W-1:0];
  assign w_wr_ctrl   = wr_en_i && (w_wr_off == ADDR_W'(SPI_CTRL));
  assign w_wr_data   = wr_en_i && (w_wr_off == ADDR_W'(SPI_DATA));
  assign w_wr_status = wr_en_i && (w_wr_off == ADDR_W'(SPI_STATUS));

  assign w_unused_bits = &{1'b0, wr_addr_i[31:ADDR_W], rd_addr_i[31:ADDR_W],
                           wr_data_i[31:CTRL_W]};

  spi_clkgen u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .i_run   (r_state == ST_SHIFT),
    .i_div   (r_div),
    .o_lead  (w_lead),
    .o_trail (w_trail),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ctrl  <= {4'b0000, DIV_RST};
      r_div   <= DIV_RST;
      r_cpha  <= 1'b0;
      r_tx    <= 8'h00;
      r_rx    <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
    end else begin
      // cs and ie act at once even mid-frame; div/cpol/cpha were copied at start
      if (w_wr_ctrl) begin
        r_ctrl <= wr_data_i[CTRL_W-1:0];
        r_cs_n <= ~wr_data_i[CTRL_CS];
      end
      if (w_wr_status && wr_data_i[STAT_DONE]) begin
        r_done <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_sck <= r_ctrl[CTRL_CPOL];
          if (w_wr_data) begin
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
            r_tx    <= wr_data_i[7:0];
            r_div   <= r_ctrl[7:0];
            r_cpha  <= r_ctrl[CTRL_CPHA];
            if (!r_ctrl[CTRL_CPHA]) begin
              r_mosi <= wr_data_i[7];
            end
          end
        end
        ST_SHIFT: begin
          if (w_lead || w_trail) begin
            r_sck <= ~r_sck;
          end
          if ((w_lead && !r_cpha) || (w_trail && r_cpha)) begin
            r_rx <= {r_rx[6:0], spi_miso};
          end
          // cpha=1 presents each bit on the leading edge; cpha=0 already shows
          // bit 7 and advances on the trailing edge
          if (w_lead && r_cpha) begin
            r_mosi <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
          end
          if (w_trail && !r_cpha) begin
            r_mosi <= r_tx[6];
            r_tx   <= {r_tx[6:0], 1'b0};
          end
          if (w_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Placed after the STATUS clear so a same-cycle clear loses
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data_o = 32'h0;
    if (w_rd_off == ADDR_W'(SPI_CTRL)) begin
      rd_data_o = {{(32-CTRL_W){1'b0}}, r_ctrl};
    end else if (w_rd_off == ADDR_W'(SPI_DATA)) begin
      rd_data_o = {24'h0, r_rx};
    end else if (w_rd_off == ADDR_W'(SPI_STATUS)) begin
      rd_data_o[STAT_BUSY] = r_busy;
      rd_data_o[STAT_DONE] = r_done;
    end
  end

  assign spi_sck        = r_sck;
  assign spi_mosi       = r_mosi;
  assign spi_cs_n       = r_cs_n;
  assign spi_int_flag_o = r_done & r_ctrl[CTRL_IE];

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master with an SPI slave model
module tb_spi_master;
  import spi_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [31:0] wr_addr_i = 32'h0;
  logic [31:0] wr_data_i = 32'h0;
  logic [31:0] rd_addr_i = 32'h0;
  wire  [31:0] rd_data_o;
  wire         spi_sck, spi_mosi, spi_cs_n, spi_int_flag_o;
  wire         spi_miso;

  // Slave model: shifts out slv_sh, captures MOSI on the master's sampling edge
  logic       r_loop = 1'b0;
  logic       slv_miso = 1'b0;
  logic       slv_active = 1'b0;
  logic       m_cpol = 1'b0;
  logic       m_cpha = 1'b0;
  logic [7:0] slv_sh = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  int         lead_cnt = 0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign spi_miso = r_loop ? spi_mosi : slv_miso;

  spi_master dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en_i        (wr_en_i),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .spi_sck        (spi_sck),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .spi_cs_n       (spi_cs_n),
    .spi_int_flag_o (spi_int_flag_o)
  );

  always @(spi_sck) begin
    if (slv_active) begin
      if (spi_sck !== m_cpol) begin
        lead_cnt++;
        if (m_cpha) begin
          slv_miso = slv_sh[7];
          slv_sh   = {slv_sh[6:0], 1'b0};
        end else begin
          slv_rx = {slv_rx[6:0], spi_mosi};
        end
      end else begin
        if (m_cpha) begin
          slv_rx = {slv_rx[6:0], spi_mosi};
        end else begin
          slv_sh   = {slv_sh[6:0], 1'b0};
          slv_miso = slv_sh[7];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [31:0] data);
    wr_en_i   = 1'b1;
    wr_addr_i = SPI_S5_BASE | {24'h0, off};
    wr_data_i = data;
    tick();
    wr_en_i   = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] off, output logic [31:0] data);
    rd_addr_i = SPI_S5_BASE | {24'h0, off};
    #1;
    data = rd_data_o;
  endtask

  // kind: 0 plain, 1 DATA write at act, 2 CTRL write at act,
  //       3 STATUS clear in the DONE cycle, 4 DATA write in the DONE cycle
  task automatic run_xfer(input string tag, input bit cpol, input bit cpha,
                          input logic [7:0] div, input logic [7:0] tx,
                          input logic [7:0] sb, input bit loop, input bit ie,
                          input int kind, input int act);
    logic [31:0] rd;
    int          n;
    int          exp_cyc;
    int          act_n;
    logic [7:0]  exp_rx;
    exp_cyc = 16 * (int'(div) + 1) + 1;
    act_n   = (kind >= 3) ? exp_cyc - 1 : act;
    exp_rx  = loop ? tx : sb;

    bus_write(SPI_CTRL, {20'h0, ie, 1'b1, cpha, cpol, div});
    tick();
    tick();
    r_loop   = loop;
    m_cpol   = cpol;
    m_cpha   = cpha;
    slv_sh   = sb;
    slv_rx   = 8'h00;
    lead_cnt = 0;
    slv_miso = cpha ? 1'b0 : sb[7];
    slv_active = 1'b1;
    bus_write(SPI_DATA, {24'h0, tx});

    rd_addr_i = SPI_S5_BASE | {24'h0, SPI_STATUS};
    n = 0;
    while (n < 16 * 257 + 8) begin
      if (kind != 0 && n == act_n) begin
        wr_en_i   = 1'b1;
        wr_addr_i = SPI_S5_BASE | {24'h0, (kind == 2) ? SPI_CTRL :
                                           (kind == 3) ? SPI_STATUS : SPI_DATA};
        wr_data_i = (kind == 2) ? {20'h0, 4'b1000, 8'd7} :
                    (kind == 3) ? 32'h2 : 32'h22;
      end
      tick();
      n++;
      wr_en_i = 1'b0;
      if (kind == 2 && n == act_n + 1) check({tag, "_cs_immediate"}, {31'h0, spi_cs_n}, 32'h1);
      if (rd_data_o[STAT_BUSY] == 1'b0) break;
    end
    slv_active = 1'b0;

    check({tag, "_done_cycle"}, n, exp_cyc);
    check({tag, "_done_flag"}, {31'h0, rd_data_o[STAT_DONE]}, 32'h1);
    check({tag, "_int"}, {31'h0, spi_int_flag_o}, {31'h0, (kind == 2) ? 1'b1 : ie});
    check({tag, "_mosi_bits"}, {24'h0, slv_rx}, {24'h0, (kind == 1) ? tx : tx});
    check({tag, "_sck_pulses"}, lead_cnt, 8);
    check({tag, "_sck_idle"}, {31'h0, spi_sck}, {31'h0, cpol});
    reg_read(SPI_DATA, rd);
    check({tag, "_rx"}, rd, {24'h0, exp_rx});

    if (kind == 1 || kind == 4) begin
      repeat (4) tick();
      reg_read(SPI_STATUS, rd);
      check({tag, "_no_restart"}, rd, 32'h2);
    end

    bus_write(SPI_STATUS, 32'h2);
    reg_read(SPI_STATUS, rd);
    check({tag, "_done_clr"}, rd, 32'h0);
    check({tag, "_int_clr"}, {31'h0, spi_int_flag_o}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        c_pol, c_pha, lp;
    logic [7:0]  dv, tx, sb;

    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_cs_n", {31'h0, spi_cs_n}, 32'h1);
    check("rst_sck", {31'h0, spi_sck}, 32'h0);
    check("rst_mosi", {31'h0, spi_mosi}, 32'h0);
    check("rst_int", {31'h0, spi_int_flag_o}, 32'h0);
    reg_read(SPI_CTRL, rd);   check("rst_ctrl", rd, 32'h18);
    reg_read(SPI_DATA, rd);   check("rst_data", rd, 32'h0);
    reg_read(SPI_STATUS, rd); check("rst_status", rd, 32'h0);

    run_xfer("m0_a5", 1'b0, 1'b0, 8'd0, 8'hA5, 8'h00, 1'b1, 1'b0, 0, 0);
    run_xfer("m3_3c", 1'b1, 1'b1, 8'd3, 8'hFF, 8'h3C, 1'b0, 1'b0, 0, 0);
    run_xfer("ie", 1'b0, 1'b1, 8'd1, 8'h96, 8'h69, 1'b0, 1'b1, 0, 0);
    run_xfer("busy_wr", 1'b0, 1'b0, 8'd0, 8'h11, 8'h00, 1'b1, 1'b0, 1, 5);
    run_xfer("ctrl_mid", 1'b1, 1'b0, 8'd1, 8'hC3, 8'h5A, 1'b0, 1'b0, 2, 3);
    run_xfer("clr_race", 1'b0, 1'b0, 8'd0, 8'h7E, 8'h81, 1'b0, 1'b0, 3, 0);
    run_xfer("data_race", 1'b0, 1'b1, 8'd0, 8'h42, 8'hBD, 1'b0, 1'b0, 4, 0);
    run_xfer("div255", 1'b0, 1'b0, 8'd255, 8'h5A, 8'hE1, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      c_pol = 1'($urandom_range(0, 1));
      c_pha = 1'($urandom_range(0, 1));
      lp    = 1'($urandom_range(0, 1));
      dv    = 8'($urandom_range(0, 4));
      tx    = 8'($urandom);
      sb    = 8'($urandom);
      run_xfer("rand", c_pol, c_pha, dv, tx, sb, lp, 1'b0, 0, 0);
    end

    // Reset in the middle of a div=0 transfer
    bus_write(SPI_CTRL, 32'h0000_0400);
    tick();
    r_loop = 1'b1;
    bus_write(SPI_DATA, 32'h5A);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cs_n", {31'h0, spi_cs_n}, 32'h1);
    check("mid_rst_sck", {31'h0, spi_sck}, 32'h0);
    check("mid_rst_mosi", {31'h0, spi_mosi}, 32'h0);
    reg_read(SPI_STATUS, rd); check("mid_rst_status", rd, 32'h0);
    reg_read(SPI_DATA, rd);   check("mid_rst_rx", rd, 32'h0);
    reg_read(SPI_CTRL, rd);   check("mid_rst_ctrl", rd, 32'h18);

    // Unmapped offsets and CTRL readback
    bus_write(8'h0C, 32'h0000_0FFF);
    reg_read(8'h0C, rd);    check("unmapped_0c", rd, 32'h0);
    reg_read(8'hFC, rd);    check("unmapped_fc", rd, 32'h0);
    reg_read(SPI_CTRL, rd); check("unmapped_wr_ignored", rd, 32'h18);
    bus_write(SPI_CTRL, 32'h0000_0403);
    reg_read(SPI_CTRL, rd); check("ctrl_readback", rd, 32'h0000_0403);
    check("ctrl_cs_n", {31'h0, spi_cs_n}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
